// File: rtl/ctl_mc_pkg.sv
// ctl_mc_pkg: opcodes, ALU function codes, select encodings, control bundle and FSM states
package ctl_mc_pkg;

    localparam logic [5:0] OP_LD  = 6'h18;
    localparam logic [5:0] OP_ST  = 6'h19;
    localparam logic [5:0] OP_JMP = 6'h1B;
    localparam logic [5:0] OP_BEQ = 6'h1D;
    localparam logic [5:0] OP_BNE = 6'h1E;
    localparam logic [5:0] OP_LDR = 6'h1F;

    localparam logic [5:0] ALU_ADD   = 6'b000000;
    localparam logic [5:0] ALU_SUB   = 6'b000001;
    localparam logic [5:0] ALU_MUL   = 6'b000010;
    localparam logic [5:0] ALU_DIV   = 6'b000011;
    localparam logic [5:0] ALU_AND   = 6'b011000;
    localparam logic [5:0] ALU_OR    = 6'b011110;
    localparam logic [5:0] ALU_XOR   = 6'b010110;
    localparam logic [5:0] ALU_XNOR  = 6'b011001;
    localparam logic [5:0] ALU_A     = 6'b011010;
    localparam logic [5:0] ALU_SHL   = 6'b100000;
    localparam logic [5:0] ALU_SHR   = 6'b100001;
    localparam logic [5:0] ALU_SRA   = 6'b100011;
    localparam logic [5:0] ALU_CMPEQ = 6'b110011;
    localparam logic [5:0] ALU_CMPLT = 6'b110101;
    localparam logic [5:0] ALU_CMPLE = 6'b110111;

    localparam logic [2:0] PCSEL_INC   = 3'd0;
    localparam logic [2:0] PCSEL_BR    = 3'd1;
    localparam logic [2:0] PCSEL_JMP   = 3'd2;
    localparam logic [2:0] PCSEL_ILLOP = 3'd3;
    localparam logic [2:0] PCSEL_XADR  = 3'd4;

    localparam logic [1:0] WDSEL_PC  = 2'd0;
    localparam logic [1:0] WDSEL_ALU = 2'd1;
    localparam logic [1:0] WDSEL_MEM = 2'd2;

    typedef enum logic [1:0] {EXEC, MULDIV, MEMW} state_t;

    typedef struct packed {
        logic [5:0] alufn;
        logic       asel;
        logic       bsel;
        logic       moe;
        logic       mwr;
        logic [2:0] pcsel;
        logic       ra2sel;
        logic       wasel;
        logic [1:0] wdsel;
        logic       werf;
    } ctl_t;

    // low opcode nibble of the ALU/ALUC groups to ALU function; x7/xF are undefined
    function automatic logic [5:0] alu_fn(input logic [3:0] f);
        case (f)
            4'h1:    return ALU_SUB;
            4'h2:    return ALU_MUL;
            4'h3:    return ALU_DIV;
            4'h4:    return ALU_CMPEQ;
            4'h5:    return ALU_CMPLT;
            4'h6:    return ALU_CMPLE;
            4'h8:    return ALU_AND;
            4'h9:    return ALU_OR;
            4'hA:    return ALU_XOR;
            4'hB:    return ALU_XNOR;
            4'hC:    return ALU_SHL;
            4'hD:    return ALU_SHR;
            4'hE:    return ALU_SRA;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/ctl_mc_if.sv
// ctl_mc_if: instruction/status inputs and control bundle between datapath (master) and controller (slave)
interface ctl_mc_if;
    logic [5:0] op;
    logic       z;
    logic       irq;
    logic       mem_ready;
    logic [5:0] alufn;
    logic       asel;
    logic       bsel;
    logic       moe;
    logic       mwr;
    logic [2:0] pcsel;
    logic       ra2sel;
    logic       wasel;
    logic [1:0] wdsel;
    logic       werf;
    logic       pc_en;
    logic       stall;
    logic       irq_ack;

    modport master (
        output op, z, irq, mem_ready,
        input  alufn, asel, bsel, moe, mwr, pcsel, ra2sel, wasel, wdsel, werf, pc_en, stall, irq_ack
    );

    modport slave (
        input  op, z, irq, mem_ready,
        output alufn, asel, bsel, moe, mwr, pcsel, ra2sel, wasel, wdsel, werf, pc_en, stall, irq_ack
    );
endinterface

// File: rtl/ctl_decode.sv
// ctl_decode: combinational op,z -> legacy control bundle plus mul/div, memory and illegal flags
module ctl_decode
    import ctl_mc_pkg::*;
(
    input  logic [5:0] op,
    input  logic       z,
    output ctl_t       ctl,
    output logic       is_muldiv,
    output logic       is_mem,
    output logic       is_illegal
);

    // ALU/ALUC groups decode by nibble; the rest by exact opcode; anything else is illegal
    always_comb begin
        ctl = '0;
        is_muldiv = 1'b0;
        is_mem = 1'b0;
        is_illegal = 1'b0;
        if (op[5] && op[2:0] != 3'b111) begin
            ctl.alufn = alu_fn(op[3:0]);
            ctl.bsel = op[4];
            ctl.wdsel = WDSEL_ALU;
            ctl.werf = 1'b1;
            is_muldiv = op[3:1] == 3'b001;
        end else begin
            case (op)
                OP_LD: begin
                    ctl.bsel = 1'b1;
                    ctl.moe = 1'b1;
                    ctl.wdsel = WDSEL_MEM;
                    ctl.werf = 1'b1;
                    is_mem = 1'b1;
                end
                OP_ST: begin
                    ctl.bsel = 1'b1;
                    ctl.mwr = 1'b1;
                    ctl.ra2sel = 1'b1;
                    is_mem = 1'b1;
                end
                OP_LDR: begin
                    ctl.alufn = ALU_A;
                    ctl.asel = 1'b1;
                    ctl.moe = 1'b1;
                    ctl.wdsel = WDSEL_MEM;
                    ctl.werf = 1'b1;
                    is_mem = 1'b1;
                end
                OP_JMP: begin
                    ctl.pcsel = PCSEL_JMP;
                    ctl.werf = 1'b1;
                end
                OP_BEQ: begin
                    ctl.pcsel = {2'b0, z};
                    ctl.werf = 1'b1;
                end
                OP_BNE: begin
                    ctl.pcsel = {2'b0, ~z};
                    ctl.werf = 1'b1;
                end
                default: is_illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/ctl_mc.sv
// ctl_mc: multi-cycle control sequencer (MUL/DIV latency, memory wait, interrupts); CTL_ILLOP_TRAP_EN enables the ILLOP trap
module ctl_mc
    import ctl_mc_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 16
) (
    input logic     clk,
    input logic     reset_n,
    ctl_mc_if.slave bus
);

    localparam int LAT_MAX = MUL_LAT > DIV_LAT ? MUL_LAT : DIV_LAT;
    localparam int CNT_W = $clog2(LAT_MAX + 1);
    localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_LAT > 1 ? MUL_LAT - 2 : 0);
    localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_LAT > 1 ? DIV_LAT - 2 : 0);
    localparam bit MUL_MC = MUL_LAT > 1;
    localparam bit DIV_MC = DIV_LAT > 1;
`ifdef CTL_ILLOP_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    state_t state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx, ld;
    logic irq_q, irq_pend;
    ctl_t dec, ctl, out;
    logic is_muldiv, is_mem, is_illegal, trap, lat_mc, commit, ack;

    ctl_decode u_decode (
        .op(bus.op),
        .z(bus.z),
        .ctl(dec),
        .is_muldiv(is_muldiv),
        .is_mem(is_mem),
        .is_illegal(is_illegal)
    );

    // op[0] separates DIV/DIVC from MUL/MULC
    assign lat_mc = bus.op[0] ? DIV_MC : MUL_MC;
    assign ld = bus.op[0] ? DIV_LD : MUL_LD;
    assign trap = TRAP_EN && is_illegal;

    // state, latency counter and interrupt edge latch; a new edge wins over a same-cycle ack
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= EXEC;
            cnt <= '0;
            irq_q <= 1'b0;
            irq_pend <= 1'b0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
            irq_q <= bus.irq;
            irq_pend <= (bus.irq & ~irq_q) | (irq_pend & ~ack);
        end
    end

    // next state: multi-cycle ops and unready memory accesses leave EXEC unless an interrupt is taken
    always_comb begin
        state_nx = state;
        cnt_nx = cnt;
        case (state)
            MULDIV: begin
                state_nx = cnt == '0 ? EXEC : MULDIV;
                cnt_nx = cnt == '0 ? cnt : cnt - 1'b1;
            end
            MEMW: state_nx = bus.mem_ready ? EXEC : MEMW;
            default: begin
                if (!irq_pend && is_muldiv && lat_mc) begin
                    state_nx = MULDIV;
                    cnt_nx = ld;
                end else if (!irq_pend && is_mem && !bus.mem_ready) begin
                    state_nx = MEMW;
                end
            end
        endcase
    end

    // outputs: decoded bundle held across the instruction, werf/pc_en only in the commit cycle
    always_comb begin
        ctl = dec;
        commit = 1'b1;
        ack = 1'b0;
        case (state)
            MULDIV: commit = cnt == '0;
            MEMW: commit = bus.mem_ready;
            default: begin
                if (irq_pend) begin
                    ctl = '0;
                    ctl.pcsel = PCSEL_XADR;
                    ctl.wasel = 1'b1;
                    ctl.wdsel = WDSEL_PC;
                    ctl.werf = 1'b1;
                    ack = 1'b1;
                end else if (trap) begin
                    ctl.pcsel = PCSEL_ILLOP;
                    ctl.wasel = 1'b1;
                    ctl.wdsel = WDSEL_PC;
                    ctl.werf = 1'b1;
                end else begin
                    commit = !(is_muldiv && lat_mc) && !(is_mem && !bus.mem_ready);
                end
            end
        endcase
        ctl.werf = ctl.werf & commit;
    end

    assign out = reset_n ? ctl : '0;
    assign bus.alufn = out.alufn;
    assign bus.asel = out.asel;
    assign bus.bsel = out.bsel;
    assign bus.moe = out.moe;
    assign bus.mwr = out.mwr;
    assign bus.pcsel = out.pcsel;
    assign bus.ra2sel = out.ra2sel;
    assign bus.wasel = out.wasel;
    assign bus.wdsel = out.wdsel;
    assign bus.werf = out.werf;
    assign bus.pc_en = reset_n & commit;
    assign bus.stall = reset_n & ~commit;
    assign bus.irq_ack = reset_n & ack;

endmodule

// File: tb/tb_ctl_mc.sv
// tb_ctl_mc: directed vectors with hand-computed control bundles for ctl_mc (MUL_LAT=4, DIV_LAT=16)
module tb_ctl_mc;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [20:0] obs;

    ctl_mc_if bus ();

    ctl_mc #(.MUL_LAT(4), .DIV_LAT(16)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    assign obs = {bus.alufn, bus.asel, bus.bsel, bus.moe, bus.mwr, bus.pcsel, bus.ra2sel,
                  bus.wasel, bus.wdsel, bus.werf, bus.pc_en, bus.stall, bus.irq_ack};

    task automatic check(input string tag, input logic [20:0] got, input logic [20:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, got, want);
        end
    endtask

    // sel = {asel,bsel,moe,mwr}; en = {werf,pc_en,stall,irq_ack}
    task automatic expect_out(input string tag, input logic [5:0] fn, input logic [3:0] sel,
                              input logic [2:0] pc, input logic ra2, input logic wa,
                              input logic [1:0] wd, input logic [3:0] en);
        check(tag, obs, {fn, sel, pc, ra2, wa, wd, en});
    endtask

    // one clock cycle: drive inputs just after the edge, check combinational outputs mid-cycle
    task automatic vec(input logic [5:0] o, input logic zz, input logic mr, input logic iq,
                       input string tag, input logic [5:0] fn, input logic [3:0] sel,
                       input logic [2:0] pc, input logic ra2, input logic wa,
                       input logic [1:0] wd, input logic [3:0] en);
        @(posedge clk);
        #1;
        bus.op = o;
        bus.z = zz;
        bus.mem_ready = mr;
        bus.irq = iq;
        #1;
        expect_out(tag, fn, sel, pc, ra2, wa, wd, en);
    endtask

    initial begin
        bus.op = 6'h30;
        bus.z = 1'b0;
        bus.irq = 1'b0;
        bus.mem_ready = 1'b0;
        #3;
        expect_out("reset", 6'h00, 4'b0000, 3'd0, 1'b0, 1'b0, 2'd0, 4'b0000);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        expect_out("addc_first", 6'h00, 4'b0100, 3'd0, 1'b0, 1'b0, 2'd1, 4'b1100);
        vec(6'h21, 1'b0, 1'b0, 1'b0, "sub", 6'h01, 4'b0000, 3'd0, 1'b0, 1'b0, 2'd1, 4'b1100);
        for (int i = 1; i <= 4; i++)
            vec(6'h22, 1'b0, 1'b0, 1'b0, $sformatf("mul_c%0d", i), 6'h02, 4'b0000, 3'd0, 1'b0, 1'b0, 2'd1,
                i == 4 ? 4'b1100 : 4'b0010);
        for (int i = 1; i <= 6; i++)
            vec(6'h19, 1'b0, i == 6, 1'b0, $sformatf("st_c%0d", i), 6'h00, 4'b0101, 3'd0, 1'b1, 1'b0, 2'd0,
                i == 6 ? 4'b0100 : 4'b0010);
        vec(6'h18, 1'b0, 1'b1, 1'b0, "ld_ready", 6'h00, 4'b0110, 3'd0, 1'b0, 1'b0, 2'd2, 4'b1100);
        vec(6'h1F, 1'b0, 1'b0, 1'b0, "ldr_wait", 6'h1A, 4'b1010, 3'd0, 1'b0, 1'b0, 2'd2, 4'b0010);
        vec(6'h1F, 1'b0, 1'b1, 1'b0, "ldr_done", 6'h1A, 4'b1010, 3'd0, 1'b0, 1'b0, 2'd2, 4'b1100);
        vec(6'h1B, 1'b0, 1'b0, 1'b0, "jmp", 6'h00, 4'b0000, 3'd2, 1'b0, 1'b0, 2'd0, 4'b1100);
        vec(6'h1D, 1'b1, 1'b0, 1'b0, "beq_taken", 6'h00, 4'b0000, 3'd1, 1'b0, 1'b0, 2'd0, 4'b1100);
        vec(6'h1D, 1'b0, 1'b0, 1'b0, "beq_fall", 6'h00, 4'b0000, 3'd0, 1'b0, 1'b0, 2'd0, 4'b1100);
        vec(6'h1E, 1'b0, 1'b0, 1'b0, "bne_taken", 6'h00, 4'b0000, 3'd1, 1'b0, 1'b0, 2'd0, 4'b1100);
        vec(6'h1E, 1'b1, 1'b0, 1'b0, "bne_fall", 6'h00, 4'b0000, 3'd0, 1'b0, 1'b0, 2'd0, 4'b1100);
        for (int i = 1; i <= 16; i++)
            vec(6'h23, 1'b0, 1'b0, i >= 2, $sformatf("div_c%0d", i), 6'h03, 4'b0000, 3'd0, 1'b0, 1'b0, 2'd1,
                i == 16 ? 4'b1100 : 4'b0010);
        vec(6'h20, 1'b0, 1'b0, 1'b1, "irq_take", 6'h00, 4'b0000, 3'd4, 1'b0, 1'b1, 2'd0, 4'b1101);
        vec(6'h20, 1'b0, 1'b0, 1'b1, "irq_cleared", 6'h00, 4'b0000, 3'd0, 1'b0, 1'b0, 2'd1, 4'b1100);
        vec(6'h22, 1'b0, 1'b0, 1'b0, "mulrst_c1", 6'h02, 4'b0000, 3'd0, 1'b0, 1'b0, 2'd1, 4'b0010);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        expect_out("mulrst_async", 6'h00, 4'b0000, 3'd0, 1'b0, 1'b0, 2'd0, 4'b0000);
        @(posedge clk);
        #2;
        expect_out("mulrst_hold", 6'h00, 4'b0000, 3'd0, 1'b0, 1'b0, 2'd0, 4'b0000);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        expect_out("mulre_c1", 6'h02, 4'b0000, 3'd0, 1'b0, 1'b0, 2'd1, 4'b0010);
        for (int i = 2; i <= 4; i++)
            vec(6'h22, 1'b0, 1'b0, 1'b0, $sformatf("mulre_c%0d", i), 6'h02, 4'b0000, 3'd0, 1'b0, 1'b0, 2'd1,
                i == 4 ? 4'b1100 : 4'b0010);
`ifdef CTL_ILLOP_TRAP_EN
        vec(6'h3F, 1'b0, 1'b0, 1'b0, "illop", 6'h00, 4'b0000, 3'd3, 1'b0, 1'b1, 2'd0, 4'b1100);
`else
        vec(6'h3F, 1'b0, 1'b0, 1'b0, "illop_nop", 6'h00, 4'b0000, 3'd0, 1'b0, 1'b0, 2'd0, 4'b0100);
`endif
        vec(6'h30, 1'b0, 1'b0, 1'b0, "addc_after", 6'h00, 4'b0100, 3'd0, 1'b0, 1'b0, 2'd1, 4'b1100);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ctl_mc.md
Name: ctl_mc

Overview:
- Multi-cycle successor to the single-cycle RISC control decoder.
- Sits between instruction fetch/decode and the datapath and drives the same control bundle: alufn, asel, bsel, moe, mwr, pcsel, ra2sel, wasel, wdsel, werf.
- Adds sequencing for variable-latency MUL/DIV, a memory ready handshake for LD/ST/LDR, and edge-latched interrupts taken only at instruction boundaries.
- Provides a pc_en/stall interface so the PC and register file update exactly once per instruction.

Parameters:
- MUL_LAT, 4, cycles for MUL/MULC (1..255); a value of 1 means single-cycle.
- DIV_LAT, 16, cycles for DIV/DIVC (1..255).
- CNT_W, derived as $clog2(max(MUL_LAT,DIV_LAT)+1), latency counter width; not overridable.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- op  in  6  opcode of the current instruction; held stable by fetch while stall=1.
- z  in  1  Ra==0 flag, sampled in the commit cycle.
- irq  in  1  interrupt request, level input; the rising edge is latched.
- mem_ready  in  1  memory completes the current LD/ST/LDR access this cycle.
- alufn  out  6  ALU function.
- pcsel  out  3  PC source: 0 = +4, 1 = branch, 2 = JMP, 3 = ILLOP, 4 = XAdr.
- wdsel  out  2  write-data source: 0 = PC+4, 1 = ALU, 2 = memory.
- asel, bsel, moe, mwr, ra2sel, wasel  out  1 each  datapath selects and memory strobes.
- werf  out  1  register-file write enable; high only in the commit cycle.
- pc_en  out  1  PC/instruction register advance; high only in the commit cycle.
- stall  out  1  instruction is held (equal to ~pc_en while out of reset).
- irq_ack  out  1  one-cycle pulse when the interrupt is taken.

Behaviour:
- States: EXEC, MULDIV, MEMW. Reset state is EXEC.
- While reset_n=0, all outputs are 0, irq_pend=0, cnt=0 and irq_q=0. This equals the legacy reset bundle: werf=0, mwr=0, pc_en=0.
- irq_q is irq registered. irq_pend sets on irq & ~irq_q and clears on irq_ack. When a set and a clear coincide, set wins.
- EXEC with irq_pend=1 takes the interrupt ahead of op:
  - Drive pcsel=4, wasel=1, wdsel=0, werf=1, pc_en=1, irq_ack=1.
  - op is not executed and is refetched after return.
- EXEC single-cycle ops (ALU, ALUC, JMP, BEQ, BNE) use the legacy bundle.
  - Commit the same cycle: werf per table, pc_en=1.
  - BEQ drives pcsel = {2'b0, z}; BNE drives pcsel = {2'b0, ~z}.
- MUL/MULC/DIV/DIVC with LAT > 1:
  - EXEC drives the bundle with werf=0, pc_en=0, stall=1, loads cnt=LAT-2, and goes to MULDIV.
  - MULDIV holds alufn/asel/bsel. If cnt=0, commit (werf=1, pc_en=1) and go to EXEC; otherwise decrement cnt.
  - Total latency is exactly LAT cycles. LAT=1 commits in EXEC.
- LD/ST/LDR:
  - EXEC drives moe/mwr per table.
  - If mem_ready=1, commit the same cycle.
  - Otherwise suppress werf and pc_en and go to MEMW.
  - MEMW holds the full bundle, including mwr, until mem_ready=1, then commits and returns to EXEC.
  - There is no timeout.
- irq edges during MULDIV/MEMW only set irq_pend; the interrupt is taken in the first EXEC cycle after the commit.
- reset_n assertion mid-operation aborts immediately: no werf and no pc_en. The instruction restarts after reset.
- Undefined opcodes: see the optional feature.
- Outputs are combinational from state, op, z, mem_ready and irq_pend. The registers are state, cnt, irq_pend and irq_q.

Optional Feature:
- Macro: CTL_ILLOP_TRAP_EN.
- Defined: an undefined op in EXEC commits the ILLOP bundle: pcsel=3, wasel=1, wdsel=0, werf=1, pc_en=1. irq_pend still has priority over ILLOP.
- Undefined: an undefined op is a NOP, with all selects 0, werf=0, pcsel=0 and pc_en=1.

Decomposition:
- Shared constants go in risc_constants.vh:
  - opcodes and alu_* codes;
  - the PCSEL_* and WDSEL_* encodings;
  - the ctl_mc state encodings.
- One sub-module, ctl_decode: purely combinational op,z -> 18-bit bundle plus is_muldiv, is_mem and is_illegal flags.
- ctl_mc owns all sequencing.

Test Plan:
- ADDC, op held, reset_n released -> werf=1, bsel=1, wdsel=1 and pc_en=1 in the first cycle. No stall.
- MUL with MUL_LAT=4 -> stall=1 for 3 cycles, then werf=1 and pc_en=1 in cycle 4. alufn=alu_MUL is held throughout.
- ST with mem_ready=0 for 5 cycles, then 1 -> mwr=1 for all 6 cycles; pc_en=1 only in the 6th; werf=0 throughout.
- irq rising in cycle 2 of DIV (DIV_LAT=16) -> DIV commits in cycle 16; irq_ack=1 with pcsel=4, wasel=1 and werf=1 in cycle 17; irq_pend=0 after.
- reset_n pulled low in cycle 2 of MUL -> all outputs are 0 asynchronously, with no werf pulse. After release, MUL restarts with full 4-cycle latency.
- op=6'h3F (undefined) -> with CTL_ILLOP_TRAP_EN: pcsel=3, wasel=1, werf=1. Without it: werf=0, pcsel=0, pc_en=1.
